// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch controller: start/stop/clear/lap sequencing over a chain of cascaded BCD digits,
// with a tick prescaler and a lap register that freezes the displayed value.
module bcd_stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 10,
  parameter int unsigned NDIG     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              lap,
  output logic [4*NDIG-1:0] digits,
  output logic              running,
  output logic              overflow,
  output logic [1:0]        state
);

  localparam int unsigned   PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  state_t            st, st_nxt;
  logic [PW-1:0]     presc;
  logic [4*NDIG-1:0] cnt, cnt_nxt, lap_q;
  logic              counting, tick, carry, wrap, lap_capture;

  assign counting = (st == RUN) || (st == LAP);
  assign tick     = counting && (presc == PMAX);

  // Ripple carry: digit k advances only when every lower digit sits at 9 on a tick.
  always_comb begin
    cnt_nxt = cnt;
    carry   = tick;
    for (int unsigned k = 0; k < NDIG; k++) begin
      if (carry)
        cnt_nxt[4*k +: 4] = (cnt[4*k +: 4] >= 4'd9) ? 4'd0 : cnt[4*k +: 4] + 4'd1;
      carry = carry && (cnt[4*k +: 4] == 4'd9);
    end
    wrap = carry;
  end

  always_comb begin
    st_nxt      = st;
    lap_capture = 1'b0;
    if (!clear) begin
      case (st)
        IDLE:    if (start) st_nxt = RUN;
        RUN: begin
          if (stop) st_nxt = PAUSE;
          else if (lap) begin
            st_nxt      = LAP;
            lap_capture = 1'b1;
          end
        end
        LAP: begin
          if (stop)     st_nxt = PAUSE;
          else if (lap) st_nxt = RUN;
        end
        PAUSE:   if (start) st_nxt = RUN;
        default: st_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= IDLE;
      presc    <= '0;
      cnt      <= '0;
      lap_q    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      st       <= IDLE;
      presc    <= '0;
      cnt      <= '0;
      lap_q    <= '0;
      overflow <= 1'b0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
      if (counting) presc <= tick ? '0 : presc + PW'(1);
      if (wrap) overflow <= 1'b1;
      // Lap snapshot takes the pre-increment count of this edge.
      if (lap_capture) lap_q <= cnt;
    end
  end

  assign digits  = (st == LAP) ? lap_q : cnt;
  assign running = counting;
  assign state   = st;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for bcd_stopwatch_ctrl: main instance TICK_DIV=4/NDIG=4, plus a
// TICK_DIV=1/NDIG=1 instance sharing the same commands.
module tb_bcd_stopwatch_ctrl;

  logic        clk, rst, start, stop, clear, lap;
  logic [15:0] digits;
  logic        running, overflow;
  logic [1:0]  state;
  logic [3:0]  d1;
  logic        run1, ov1;
  logic [1:0]  st1;

  int checks = 0;
  int errors = 0;
  bit bad_bcd = 1'b0;

  bcd_stopwatch_ctrl #(.TICK_DIV(4), .NDIG(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .digits(digits), .running(running), .overflow(overflow), .state(state)
  );

  bcd_stopwatch_ctrl #(.TICK_DIV(1), .NDIG(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .digits(d1), .running(run1), .overflow(ov1), .state(st1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n edges, sampling 1 time unit after each; flag any non-BCD nibble.
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
        if (digits[4*i +: 4] > 4'd9) bad_bcd = 1'b1;
    end
  endtask

  task automatic cmd(input bit c_clear, input bit c_stop, input bit c_start, input bit c_lap);
    clear = c_clear; stop = c_stop; start = c_start; lap = c_lap;
    run(1);
    clear = 1'b0; stop = 1'b0; start = 1'b0; lap = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_digits", digits, 16'h0000);
    chk("rst_state", {14'b0, state}, 16'd0);
    chk("rst_running", {15'b0, running}, 16'd0);
    chk("rst_overflow", {15'b0, overflow}, 16'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Asynchronous reset mid-cycle after 10 running cycles
    cmd(0, 0, 1, 0);
    run(10);
    chk("pre_rst_digits", digits, 16'h0002);
    chk("pre_rst_state", {14'b0, state}, 16'd1);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_digits", digits, 16'h0000);
    chk("async_rst_state", {14'b0, state}, 16'd0);
    chk("async_rst_running", {15'b0, running}, 16'd0);
    chk("async_rst_overflow", {15'b0, overflow}, 16'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Basic count, pause, resume keeping prescaler phase
    cmd(0, 0, 1, 0);
    run(40);
    chk("run40_digits", digits, 16'h0010);
    chk("run40_running", {15'b0, running}, 16'd1);
    cmd(0, 1, 0, 0);
    run(20);
    chk("pause_digits", digits, 16'h0010);
    chk("pause_state", {14'b0, state}, 16'd3);
    cmd(0, 0, 1, 0);
    run(4);
    chk("resume_digits", digits, 16'h0011);

    // IDLE ignores stop/lap
    cmd(1, 0, 0, 0);
    cmd(0, 1, 0, 1);
    chk("idle_ignore_state", {14'b0, state}, 16'd0);

    // Cascades
    cmd(0, 0, 1, 0);
    run(396);
    chk("casc_0099", digits, 16'h0099);
    run(4);
    chk("casc_0100", digits, 16'h0100);
    cmd(1, 0, 0, 0);
    cmd(0, 0, 1, 0);
    run(3996);
    chk("casc_0999", digits, 16'h0999);
    run(4);
    chk("casc_1000", digits, 16'h1000);

    // Lap freeze and release
    cmd(1, 0, 0, 0);
    cmd(0, 0, 1, 0);
    run(100);
    chk("lap_pre", digits, 16'h0025);
    cmd(0, 0, 0, 1);
    chk("lap_state", {14'b0, state}, 16'd2);
    chk("lap_frozen0", digits, 16'h0025);
    run(20);
    chk("lap_frozen20", digits, 16'h0025);
    chk("lap_running", {15'b0, running}, 16'd1);
    cmd(0, 0, 0, 1);
    chk("unlap_state", {14'b0, state}, 16'd1);
    chk("unlap_digits", digits, 16'h0030);
    cmd(0, 0, 0, 1);
    cmd(0, 1, 0, 0);
    chk("lap_stop_state", {14'b0, state}, 16'd3);
    chk("lap_stop_digits", digits, 16'h0031);
    cmd(0, 0, 0, 1);
    chk("pause_ignore_lap", {14'b0, state}, 16'd3);

    // Priority and collisions
    cmd(1, 0, 0, 0);
    cmd(0, 0, 1, 0);
    run(5);
    cmd(1, 0, 1, 0);
    chk("clr_start_state", {14'b0, state}, 16'd0);
    chk("clr_start_digits", digits, 16'h0000);
    cmd(0, 0, 1, 0);
    run(2);
    cmd(0, 1, 1, 0);
    chk("stop_start_state", {14'b0, state}, 16'd3);
    cmd(1, 0, 0, 0);
    cmd(0, 0, 1, 0);
    run(28);
    chk("tick_stop_pre", digits, 16'h0007);
    run(3);
    cmd(0, 1, 0, 0);
    chk("tick_stop_state", {14'b0, state}, 16'd3);
    chk("tick_stop_digits", digits, 16'h0008);
    cmd(0, 0, 1, 0);
    run(3);
    cmd(1, 0, 0, 0);
    chk("tick_clear_digits", digits, 16'h0000);
    chk("tick_clear_state", {14'b0, state}, 16'd0);

    // Overflow: single-digit TICK_DIV=1 instance, then the full 4-digit chain
    cmd(0, 0, 1, 0);
    run(9);
    chk("u1_nine", {12'b0, d1}, 16'h0009);
    chk("u1_no_ovf", {15'b0, ov1}, 16'd0);
    run(1);
    chk("u1_wrap", {12'b0, d1}, 16'h0000);
    chk("u1_ovf", {15'b0, ov1}, 16'd1);
    chk("u1_running", {15'b0, run1}, 16'd1);
    run(39986);
    chk("ovf_9999", digits, 16'h9999);
    chk("ovf_not_yet", {15'b0, overflow}, 16'd0);
    run(4);
    chk("ovf_wrap", digits, 16'h0000);
    chk("ovf_flag", {15'b0, overflow}, 16'd1);
    chk("ovf_running", {15'b0, running}, 16'd1);
    run(8);
    chk("ovf_sticky", {15'b0, overflow}, 16'd1);
    chk("ovf_continues", digits, 16'h0002);
    cmd(1, 0, 0, 0);
    chk("ovf_clear_flag", {15'b0, overflow}, 16'd0);
    chk("ovf_clear_state", {14'b0, state}, 16'd0);

    chk("bcd_valid", {15'b0, bad_bcd}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
